// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word requests to the I-cache,
// and queues returned instructions with their PCs for decode. Redirects flush and drop stale responses.
module ifetch_unit #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           QUEUE_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             redirect_valid,
   input  logic [ADDR_WIDTH-1:0]            redirect_pc,
   output logic                             icache_req,
   output logic [ADDR_WIDTH-1:0]            icache_addr,
   input  logic [DATA_WIDTH-1:0]            icache_data,
   input  logic                             icache_valid,
   input  logic                             icache_stall,
   output logic                             inst_valid,
   output logic [DATA_WIDTH-1:0]            inst_data,
   output logic [ADDR_WIDTH-1:0]            inst_pc,
   input  logic                             deq_ready,
   output logic [$clog2(QUEUE_DEPTH):0]     queue_count,
   output logic                             fetch_discard
);

   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] resp_pc;
   logic                  pending;
   logic                  discard_pending;

   logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [CNT_W-1:0]      count;

   logic issue;
   logic resp;
   logic enq;
   logic deq;
   logic drop;

   // Stall is advisory only (a miss just holds pending); low PC bits are forced to zero.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, icache_stall, redirect_pc[1:0]};

   // Outstanding response is credited against queue space; same-cycle dequeue is not.
   always_comb begin
      resp  = icache_valid && pending;
      issue = rst_n && !redirect_valid && (!pending || icache_valid) &&
              ((count + CNT_W'(pending)) < CNT_W'(QUEUE_DEPTH));
      enq   = resp && !discard_pending && !redirect_valid;
      deq   = (count != '0) && deq_ready && !redirect_valid;
      drop  = resp && (discard_pending || redirect_valid);
   end

   always_comb begin
      icache_req  = issue;
      icache_addr = pc;
      queue_count = count;
      inst_valid  = (count != '0);
      inst_data   = inst_valid ? q_data[head] : '0;
      inst_pc     = inst_valid ? q_pc[head]   : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc              <= RESET_PC;
         resp_pc         <= '0;
         pending         <= 1'b0;
         discard_pending <= 1'b0;
         fetch_discard   <= 1'b0;
      end else begin
         fetch_discard <= drop;
         if (redirect_valid)
            pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         else if (issue)
            pc <= pc + ADDR_WIDTH'(4);
         if (issue) begin
            resp_pc         <= pc;
            pending         <= 1'b1;
            discard_pending <= 1'b0;
         end else begin
            if (icache_valid)
               pending <= 1'b0;
            if (redirect_valid && pending && !icache_valid)
               discard_pending <= 1'b1;
            else if (icache_valid)
               discard_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect_valid) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq)
            tail <= tail + PTR_W'(1);
         if (deq)
            head <= head + PTR_W'(1);
         if (enq && !deq)
            count <= count + CNT_W'(1);
         else if (deq && !enq)
            count <= count - CNT_W'(1);
      end
   end

   // Storage needs no reset: the head is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (enq) begin
         q_data[tail] <= icache_data;
         q_pc[tail]   <= resp_pc;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: behavioural I-cache, program-order scoreboard,
// directed scenarios for hits, misses, back-pressure, redirects and PC wrap, then random traffic.
module tb_ifetch_unit;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          icache_req;
   logic [AW-1:0] icache_addr;
   logic [DW-1:0] icache_data;
   logic          icache_valid;
   logic          icache_stall;
   logic          inst_valid;
   logic [DW-1:0] inst_data;
   logic [AW-1:0] inst_pc;
   logic          deq_ready;
   logic [2:0]    queue_count;
   logic          fetch_discard;

   always #5 clk = ~clk;

   ifetch_unit #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .QUEUE_DEPTH(DEPTH),
      .RESET_PC   (RPC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .icache_req    (icache_req),
      .icache_addr   (icache_addr),
      .icache_data   (icache_data),
      .icache_valid  (icache_valid),
      .icache_stall  (icache_stall),
      .inst_valid    (inst_valid),
      .inst_data     (inst_data),
      .inst_pc       (inst_pc),
      .deq_ready     (deq_ready),
      .queue_count   (queue_count),
      .fetch_discard (fetch_discard)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   int errors = 0;
   int checks = 0;
   int pops   = 0;

   // Program-order expectation: instructions the decode stage should see, oldest first.
   ent_t        exp_q[$];
   logic [31:0] model_pc;
   // Cache model: one owed response, cycles until it returns, and whether a redirect made it stale.
   bit          owed;
   bit          stale;
   int          lat;
   logic [31:0] owed_pc;
   int          occ;
   bit          exp_disc;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Decode-side monitor: every accepted head must be the next instruction in program order.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && inst_valid === 1'b1 && deq_ready === 1'b1 && redirect_valid === 1'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL deq_unexpected: got pc %h with nothing expected (t=%0t)", inst_pc, $time);
            end else begin
               ent_t e;
               e = exp_q.pop_front();
               chk("inst_pc", inst_pc, e.pc);
               chk("inst_data", inst_data, e.data);
               pops++;
            end
         end
      end
   end

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      icache_valid   = 1'b0;
      icache_data    = '0;
      icache_stall   = 1'b0;
      deq_ready      = 1'b0;
      owed = 0; stale = 0; lat = 0; occ = 0; exp_disc = 0;
      model_pc = RPC;
      exp_q.delete();
      #1;
      chk("rst_icache_req", icache_req, 0);
      chk("rst_icache_addr", icache_addr, RPC);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst_data", inst_data, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_queue_count", queue_count, 0);
      chk("rst_fetch_discard", fetch_discard, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive inputs just after posedge, check at negedge, end just after next posedge.
   task automatic step(input bit redir, input logic [31:0] rpc, input bit deq, input int hit_pct,
                       input int miss_lat, output bit r, output logic [31:0] a, output int qc,
                       output bit disc);
      bit resp;
      bit exp_req;
      resp = owed && (lat == 0);
      icache_valid   = resp;
      icache_data    = resp ? mem(owed_pc) : $urandom;
      icache_stall   = owed && (lat != 0);
      redirect_valid = redir;
      redirect_pc    = rpc;
      deq_ready      = deq;
      if (redir) begin
         if (owed) stale = 1;
         exp_q.delete();
         model_pc = {rpc[31:2], 2'b00};
      end
      @(negedge clk);
      r    = icache_req;
      a    = icache_addr;
      qc   = int'(queue_count);
      disc = fetch_discard;
      exp_req = !redir && (!owed || resp) && ((occ + int'(owed)) < int'(DEPTH));
      chk("icache_req", icache_req, exp_req);
      chk("queue_count", queue_count, occ);
      chk("inst_valid", inst_valid, occ != 0);
      chk("fetch_discard", fetch_discard, exp_disc);
      chk("no_overflow", queue_count <= DEPTH, 1);
      exp_disc = resp && stale;
      if (redir) occ = 0;
      else occ = occ + int'(resp && !stale) - int'(occ != 0 && deq);
      if (icache_req === 1'b1) begin
         chk("icache_addr", icache_addr, model_pc);
         exp_q.push_back('{pc: model_pc, data: mem(model_pc)});
         owed_pc  = model_pc;
         model_pc = model_pc + 32'd4;
         owed  = 1;
         stale = 0;
         lat   = ($urandom_range(99) < hit_pct) ? 0 : miss_lat;
      end else if (resp) begin
         owed  = 0;
         stale = 0;
      end else if (owed) begin
         lat--;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          r;
      bit          d;
      logic [31:0] a;
      logic [31:0] first_a;
      int          qc;
      int          nreq;
      int          ndisc;
      bit          got;

      do_reset();

      // Warm cache, decode always ready: back-to-back hits.
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 100, 1, r, a, qc, d);
         chk("t1_req", r, 1);
         chk("t1_addr", a, 32'(i * 4));
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 100, 1, r, a, qc, d);
         chk("t1_qc_le1", qc <= 1, 1);
      end

      // Cold cache, latency 3: one request, silence, next request in the response cycle.
      do_reset();
      step(0, 0, 1, 0, 3, r, a, qc, d);
      chk("t2_req0", r, 1);
      chk("t2_addr0", a, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 100, 1, r, a, qc, d);
         chk("t2_quiet", r, 0);
      end
      step(0, 0, 1, 100, 1, r, a, qc, d);
      chk("t2_req1", r, 1);
      chk("t2_addr1", a, 32'h4);
      repeat (3) step(0, 0, 1, 100, 1, r, a, qc, d);

      // Decode stalled: fill to capacity, then one freed slot re-enables fetch.
      do_reset();
      nreq = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 100, 1, r, a, qc, d);
         nreq += int'(r);
      end
      chk("t3_nreq", nreq, 4);
      chk("t3_full", qc, 4);
      step(0, 0, 1, 100, 1, r, a, qc, d);
      chk("t3_deq_cycle_req", r, 0);
      step(0, 0, 1, 100, 1, r, a, qc, d);
      chk("t3_refill_req", r, 1);
      chk("t3_refill_addr", a, 32'h10);
      repeat (6) step(0, 0, 1, 100, 1, r, a, qc, d);

      // Redirect during an outstanding miss: stale response dropped, fetch resumes at target.
      do_reset();
      step(1, 32'h40, 1, 100, 1, r, a, qc, d);
      step(0, 0, 1, 0, 4, r, a, qc, d);
      chk("t4_miss_req", r, 1);
      chk("t4_miss_addr", a, 32'h40);
      step(1, 32'h103, 1, 100, 1, r, a, qc, d);
      ndisc = 0;
      got = 0;
      first_a = 'x;
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, 100, 1, r, a, qc, d);
         if (i == 0) chk("t4_flushed", qc, 0);
         ndisc += int'(d);
         if (r && !got) begin
            got = 1;
            first_a = a;
         end
      end
      chk("t4_disc_pulses", ndisc, 1);
      chk("t4_first_addr", first_a, 32'h100);

      // Redirect in the same cycle a hit returns.
      do_reset();
      step(0, 0, 1, 100, 1, r, a, qc, d);
      step(1, 32'h200, 1, 100, 1, r, a, qc, d);
      step(0, 0, 1, 100, 1, r, a, qc, d);
      chk("t5_disc", d, 1);
      chk("t5_req", r, 1);
      chk("t5_addr", a, 32'h200);
      repeat (4) step(0, 0, 1, 100, 1, r, a, qc, d);

      // PC wrap at the top of the address space.
      do_reset();
      step(1, 32'hFFFF_FFFC, 1, 100, 1, r, a, qc, d);
      step(0, 0, 1, 100, 1, r, a, qc, d);
      chk("t6_req_top", r, 1);
      chk("t6_addr_top", a, 32'hFFFF_FFFC);
      step(0, 0, 1, 100, 1, r, a, qc, d);
      chk("t6_req_wrap", r, 1);
      chk("t6_addr_wrap", a, 32'h0);
      repeat (4) step(0, 0, 1, 100, 1, r, a, qc, d);

      // Random traffic with a reset landed in the middle of a miss.
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         step($urandom_range(99) < 4, $urandom, $urandom_range(99) < 70, 70,
              $urandom_range(1, 5), r, a, qc, d);
         if (i == 1200) begin
            for (int k = 0; k < 40 && !(owed && lat > 0); k++)
               step(0, 0, 1, 0, 5, r, a, qc, d);
            chk("midmiss_reached", owed && lat > 0, 1);
            do_reset();
         end
      end
      repeat (10) step(0, 0, 1, 100, 1, r, a, qc, d);
      chk("progress", pops >= 300, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
